// File: rtl/axis_axi_frame_writer.sv
// -----------------------------------------------------------------------------
// axis_axi_frame_writer
//
// AXI-Stream sink that stores a frame of stream beats linearly into an AXI
// memory starting at BASE_ADDR, using INCR write bursts of up to BURST_LEN
// beats. Incoming beats are buffered in a BURST_LEN-deep FIFO. A burst is only
// requested once all of its data is buffered, either because the FIFO is full
// or because the frame's tlast beat is held. As a result, W never waits on the
// stream.
//
// Optional feature macro: AXIS_WR_TKEEP_EN
//   defined   : s_axis_tkeep port exists, is stored per beat, drives m_axi_wstrb
//   undefined : no tkeep port or storage, m_axi_wstrb is all ones
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   s_axis_t{data,keep,valid,last} stream input; s_axis_tready back-pressure
//   m_axi_aw*                      write address channel (awid = 0, INCR)
//   m_axi_w*                       write data channel
//   m_axi_b*                       write response channel (bid ignored)
//   frame_done                     1-cycle pulse after the final burst's B
//   wr_err                         sticky flag, any non-OKAY bresp
// -----------------------------------------------------------------------------
module axis_axi_frame_writer #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
    parameter int                    ID_WIDTH   = 8,
    parameter int                    BURST_LEN  = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
`ifdef AXIS_WR_TKEEP_EN
    input  logic [STRB_WIDTH-1:0] s_axis_tkeep,
`endif
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic                  frame_done,
    output logic                  wr_err
);

    localparam int PTR_W  = $clog2(BURST_LEN);
    localparam int CNT_W  = PTR_W + 1;
    localparam int SIZE_W = $clog2(STRB_WIDTH);
`ifdef AXIS_WR_TKEEP_EN
    localparam int ENTRY_W = 1 + STRB_WIDTH + DATA_WIDTH;
`else
    localparam int ENTRY_W = 1 + DATA_WIDTH;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;

    logic [ENTRY_W-1:0]    mem_r [BURST_LEN];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic [CNT_W-1:0]      beats_r;
    logic [CNT_W-1:0]      remain_r;
    logic [ADDR_WIDTH-1:0] cur_addr_r;
    logic                  last_pend_r;
    logic                  has_last_r;
    logic                  frame_done_r;
    logic                  wr_err_r;

    logic                  full_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  trigger_s;
    logic                  b_hs_s;
    logic [ENTRY_W-1:0]    in_entry_s;
    logic [ENTRY_W-1:0]    head_s;
    logic                  head_last_s;
    logic                  awvalid_s;
    logic                  wvalid_s;
    logic                  wlast_s;
    logic                  bready_s;
    logic                  unused_bid_s;

    // Response IDs carry no information for a single-ID master.
    assign unused_bid_s = ^m_axi_bid;

    assign full_s        = (count_r == CNT_W'(BURST_LEN));
    // Stream is frozen from the tlast beat until that frame's final B returns.
    assign s_axis_tready = !full_s && !last_pend_r && rst_n;
    assign push_s        = s_axis_tvalid && s_axis_tready;
    assign pop_s         = wvalid_s && m_axi_wready;
    assign b_hs_s        = bready_s && m_axi_bvalid;
    // A burst only starts when its data is fully buffered.
    assign trigger_s     = (full_s || last_pend_r) && (count_r != {CNT_W{1'b0}});

`ifdef AXIS_WR_TKEEP_EN
    assign in_entry_s  = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    assign m_axi_wstrb = head_s[DATA_WIDTH +: STRB_WIDTH];
`else
    assign in_entry_s  = {s_axis_tlast, s_axis_tdata};
    assign m_axi_wstrb = {STRB_WIDTH{1'b1}};
`endif
    assign head_s      = mem_r[rd_ptr_r];
    assign head_last_s = head_s[ENTRY_W-1];
    assign m_axi_wdata = head_s[DATA_WIDTH-1:0];

    assign m_axi_awid    = {ID_WIDTH{1'b0}};
    assign m_axi_awsize  = 3'(SIZE_W);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awaddr  = cur_addr_r;
    assign m_axi_awlen   = 8'(beats_r - CNT_W'(1'b1));
    assign m_axi_awvalid = awvalid_s;
    assign m_axi_wvalid  = wvalid_s;
    assign m_axi_wlast   = wlast_s;
    assign m_axi_bready  = bready_s;
    assign frame_done    = frame_done_r;
    assign wr_err        = wr_err_r;

    // FIFO storage: data only, no reset needed since count_r gates validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_entry_s;
        end
    end

    // FIFO pointers and occupancy; push+pop in one cycle keeps the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (trigger_s) state_nxt_s = ST_AW;
                else           state_nxt_s = ST_IDLE;
            end
            ST_AW: begin
                if (m_axi_awready) state_nxt_s = ST_W;
                else               state_nxt_s = ST_AW;
            end
            ST_W: begin
                if (pop_s && (remain_r == CNT_W'(1'b1))) state_nxt_s = ST_B;
                else                                      state_nxt_s = ST_W;
            end
            ST_B: begin
                if (m_axi_bvalid) state_nxt_s = ST_IDLE;
                else              state_nxt_s = ST_B;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs, decoded from the state register only.
    always_comb begin
        awvalid_s = 1'b0;
        wvalid_s  = 1'b0;
        wlast_s   = 1'b0;
        bready_s  = 1'b0;
        case (state_r)
            ST_AW: awvalid_s = 1'b1;
            ST_W: begin
                wvalid_s = 1'b1;
                wlast_s  = (remain_r == CNT_W'(1'b1));
            end
            ST_B:    bready_s = 1'b1;
            default: begin
                awvalid_s = 1'b0;
                wvalid_s  = 1'b0;
                wlast_s   = 1'b0;
                bready_s  = 1'b0;
            end
        endcase
    end

    // Burst bookkeeping: length latch, beat countdown, address, frame status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_r      <= {CNT_W{1'b0}};
            remain_r     <= {CNT_W{1'b0}};
            cur_addr_r   <= BASE_ADDR;
            last_pend_r  <= 1'b0;
            has_last_r   <= 1'b0;
            frame_done_r <= 1'b0;
            wr_err_r     <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            if (push_s && s_axis_tlast) begin
                last_pend_r <= 1'b1;
            end
            if ((state_r == ST_IDLE) && trigger_s) begin
                beats_r  <= count_r;
                remain_r <= count_r;
            end
            if (pop_s) begin
                remain_r <= remain_r - CNT_W'(1'b1);
                if (head_last_s) begin
                    has_last_r <= 1'b1;
                end
            end
            if (b_hs_s) begin
                if (m_axi_bresp != 2'b00) begin
                    wr_err_r <= 1'b1;
                end
                if (has_last_r) begin
                    // Frame complete: rewind and reopen the stream.
                    cur_addr_r   <= BASE_ADDR;
                    frame_done_r <= 1'b1;
                    last_pend_r  <= 1'b0;
                    has_last_r   <= 1'b0;
                end else begin
                    cur_addr_r <= cur_addr_r + (ADDR_WIDTH'(beats_r) << SIZE_W);
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_axi_frame_writer.sv
`timescale 1ns/1ps
module tb_axis_axi_frame_writer;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int SW = 4;
    localparam int IW = 8;
    localparam int BL = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] s_axis_tdata  = '0;
    logic [SW-1:0] s_axis_tkeep  = 4'hF;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast  = 1'b0;
    logic [IW-1:0] m_axi_awid;
    logic [AW-1:0] m_axi_awaddr;
    logic [7:0]    m_axi_awlen;
    logic [2:0]    m_axi_awsize;
    logic [1:0]    m_axi_awburst;
    logic          m_axi_awvalid;
    logic          m_axi_awready = 1'b1;
    logic [DW-1:0] m_axi_wdata;
    logic [SW-1:0] m_axi_wstrb;
    logic          m_axi_wlast;
    logic          m_axi_wvalid;
    logic          m_axi_wready  = 1'b1;
    logic [IW-1:0] m_axi_bid     = 8'h5A;
    logic [1:0]    m_axi_bresp   = 2'b00;
    logic          m_axi_bvalid  = 1'b0;
    logic          m_axi_bready;
    logic          frame_done;
    logic          wr_err;

    int checks   = 0;
    int failures = 0;

    // scoreboard queues: AW = {addr, len}, W = {strb, last, data}
    logic [AW+8-1:0]   aw_q [$];
    logic [SW+1+DW-1:0] w_q [$];
    logic [AW+8-1:0]   exp_aw;
    logic [SW+1+DW-1:0] exp_w;

    int fd_cnt   = 0;
    int fd_exp   = 0;
    int aw_done  = 0;
    int w_bursts = 0;
    int wl_seen  = 0;
    int bh_seen  = 0;
    int b_given  = 0;
    int err_at   = -1;
    logic          fd_prev    = 1'b0;
    logic          stall_prev = 1'b0;
    logic [AW-1:0] stall_addr = '0;
    logic [7:0]    stall_len  = '0;

    axis_axi_frame_writer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW),
        .BURST_LEN(BL), .BASE_ADDR(16'h0000)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata),
`ifdef AXIS_WR_TKEEP_EN
        .s_axis_tkeep(s_axis_tkeep),
`endif
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .frame_done(frame_done), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    // Monitor: sampled on the falling edge, handshakes complete on the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            aw_done = 0; w_bursts = 0; wl_seen = 0; bh_seen = 0;
            stall_prev = 1'b0; fd_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== stall_addr || m_axi_awlen !== stall_len) begin
                    failures++;
                    $display("FAIL aw_stable: got valid=%b addr=%h len=%0d, want valid=1 addr=%h len=%0d",
                             m_axi_awvalid, m_axi_awaddr, m_axi_awlen, stall_addr, stall_len);
                end
            end
            stall_prev = m_axi_awvalid && !m_axi_awready;
            stall_addr = m_axi_awaddr;
            stall_len  = m_axi_awlen;
            if (m_axi_wvalid) begin
                checks++;
                if (aw_done <= w_bursts) begin
                    failures++;
                    $display("FAIL w_before_aw: got wvalid with aw_accepted=%0d bursts_written=%0d, want aw_accepted > bursts_written",
                             aw_done, w_bursts);
                end
            end
            if (m_axi_awvalid && m_axi_awready) begin
                checks++;
                if (aw_q.size() == 0) begin
                    failures++;
                    $display("FAIL aw_unexpected: got addr=%h len=%0d, want no AW", m_axi_awaddr, m_axi_awlen);
                end else begin
                    exp_aw = aw_q.pop_front();
                    if ({m_axi_awaddr, m_axi_awlen} !== exp_aw || m_axi_awsize !== 3'd2 ||
                        m_axi_awburst !== 2'b01 || m_axi_awid !== 8'h00) begin
                        failures++;
                        $display("FAIL aw_beat: got addr=%h len=%0d size=%0d burst=%b id=%h, want addr=%h len=%0d size=2 burst=01 id=00",
                                 m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awid,
                                 exp_aw[AW+7:8], exp_aw[7:0]);
                    end
                end
                aw_done++;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                checks++;
                if (w_q.size() == 0) begin
                    failures++;
                    $display("FAIL w_unexpected: got data=%h last=%b, want no W", m_axi_wdata, m_axi_wlast);
                end else begin
                    exp_w = w_q.pop_front();
                    if ({m_axi_wstrb, m_axi_wlast, m_axi_wdata} !== exp_w) begin
                        failures++;
                        $display("FAIL w_beat: got strb=%b last=%b data=%h, want strb=%b last=%b data=%h",
                                 m_axi_wstrb, m_axi_wlast, m_axi_wdata,
                                 exp_w[SW+DW:DW+1], exp_w[DW], exp_w[DW-1:0]);
                    end
                end
                if (m_axi_wlast) begin
                    wl_seen++;
                    w_bursts++;
                end
            end
            if (m_axi_bvalid && m_axi_bready) bh_seen++;
            if (frame_done) begin
                fd_cnt++;
                checks++;
                if (fd_prev) begin
                    failures++;
                    $display("FAIL frame_done_width: got high 2 cycles, want 1-cycle pulse");
                end
            end
            fd_prev = frame_done;
        end
    end

    // Slave B responder: one response per completed W burst.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            m_axi_bvalid = 1'b0;
            m_axi_bresp  = 2'b00;
            b_given      = 0;
        end else begin
            if (m_axi_bvalid && bh_seen == b_given) m_axi_bvalid = 1'b0;
            if (!m_axi_bvalid && wl_seen > b_given) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = (b_given == err_at) ? 2'b10 : 2'b00;
                b_given++;
            end
        end
    end

    // Sends one frame; expected AW/W traffic is queued before driving.
    task automatic send_frame(input int n, input int d0, input logic [SW-1:0] keep);
        int k;
        int beats;
        logic [SW-1:0] strb;
`ifdef AXIS_WR_TKEEP_EN
        strb = keep;
`else
        strb = 4'hF;
`endif
        for (int b = 0; b * BL < n; b++) begin
            beats = ((n - b * BL) < BL) ? (n - b * BL) : BL;
            aw_q.push_back({16'(b * BL * SW), 8'(beats - 1)});
        end
        for (int i = 0; i < n; i++) begin
            w_q.push_back({strb, ((i % BL) == BL - 1) || (i == n - 1), 32'(d0 + i)});
        end
        fd_exp++;
        for (int i = 0; i < n; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'(d0 + i);
            s_axis_tlast  = (i == n - 1);
            s_axis_tkeep  = keep;
            k = 0;
            @(negedge clk);
            while (!s_axis_tready && k < 500) begin
                @(negedge clk);
                k++;
            end
            if (k >= 500) begin
                checks++;
                failures++;
                $display("FAIL stream_timeout: got tready=0 for 500 cycles on beat %0d, want acceptance", i);
            end
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        int k;
        k = 0;
        while (fd_cnt < fd_exp && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (fd_cnt != fd_exp) begin
            failures++;
            $display("FAIL %s_frame_done: got count=%0d, want %0d", tag, fd_cnt, fd_exp);
        end
        checks++;
        if (aw_q.size() != 0 || w_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: got aw_left=%0d w_left=%0d, want 0/0", tag, aw_q.size(), w_q.size());
        end
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, frame_done, wr_err, s_axis_tready} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs: got awv=%b wv=%b br=%b fd=%b err=%b trdy=%b, want all 0",
                     m_axi_awvalid, m_axi_wvalid, m_axi_bready, frame_done, wr_err, s_axis_tready);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (s_axis_tready !== 1'b1) begin
            failures++;
            $display("FAIL reset_tready: got %b, want 1", s_axis_tready);
        end
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, frame_done, wr_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_idle: got awv=%b wv=%b br=%b fd=%b err=%b, want all 0",
                     m_axi_awvalid, m_axi_wvalid, m_axi_bready, frame_done, wr_err);
        end
    endtask

    task automatic test_two_bursts();
        send_frame(8, 0, 4'hF);
        wait_frame("two_bursts");
    endtask

    task automatic test_short_frame();
        send_frame(3, 32'h100, 4'hF);
        checks++;
        if (s_axis_tready !== 1'b0) begin
            failures++;
            $display("FAIL short_last_pend: got tready=%b after tlast, want 0", s_axis_tready);
        end
        wait_frame("short_frame");
        checks++;
        if (s_axis_tready !== 1'b1) begin
            failures++;
            $display("FAIL short_reopen: got tready=%b after frame_done, want 1", s_axis_tready);
        end
    endtask

    task automatic test_aw_stall();
        m_axi_awready = 1'b0;
        fork
            send_frame(8, 32'h200, 4'hF);
            begin
                repeat (10) @(posedge clk);
                #1;
                checks++;
                if (s_axis_tready !== 1'b0 || m_axi_wvalid !== 1'b0 || m_axi_awvalid !== 1'b1) begin
                    failures++;
                    $display("FAIL aw_stall_state: got tready=%b wvalid=%b awvalid=%b, want 0/0/1",
                             s_axis_tready, m_axi_wvalid, m_axi_awvalid);
                end
                m_axi_awready = 1'b1;
            end
        join
        wait_frame("aw_stall");
    endtask

    task automatic test_bresp_err();
        err_at = b_given;
        send_frame(8, 32'h300, 4'hF);
        wait_frame("bresp_err");
        checks++;
        if (wr_err !== 1'b1) begin
            failures++;
            $display("FAIL bresp_err_set: got wr_err=%b, want 1", wr_err);
        end
        err_at = -1;
        send_frame(3, 32'h400, 4'hF);
        wait_frame("bresp_err_next");
        checks++;
        if (wr_err !== 1'b1) begin
            failures++;
            $display("FAIL bresp_err_sticky: got wr_err=%b, want 1", wr_err);
        end
    endtask

    task automatic test_reset_mid_burst();
        int k;
        m_axi_wready = 1'b0;
        send_frame(4, 32'h500, 4'hF);
        k = 0;
        while (!m_axi_wvalid && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        m_axi_wready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, frame_done, wr_err, s_axis_tready} !== 6'b0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got awv=%b wv=%b br=%b fd=%b err=%b trdy=%b, want all 0",
                     m_axi_awvalid, m_axi_wvalid, m_axi_bready, frame_done, wr_err, s_axis_tready);
        end
        aw_q.delete();
        w_q.delete();
        fd_exp = fd_cnt;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(4, 32'h600, 4'hF);
        wait_frame("mid_reset");
    endtask

    task automatic test_strobe();
        send_frame(4, 32'h700, 4'b0011);
        wait_frame("strobe");
    endtask

    initial begin
        test_reset();
        test_two_bursts();
        test_short_frame();
        test_aw_stall();
        test_bresp_err();
        test_reset_mid_burst();
        test_strobe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500000 ns, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
